// File: rtl/ex_case_pkg.sv
// ex_case_pkg
//   Shared definitions for the ex_case burst arbiter slice:
//   - default widths for the datapath address/data/length/response buses
//   - requester id constants (id doubles as the cmd_data MSB tag)
//   - sequencer state encoding
package ex_case_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 10;
  localparam int LEN_W_DEF     = 9;
  localparam int RSP_W_DEF     = 8;
  localparam int DRAIN_CYC_DEF = 4;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ex_case_rr_arb.sv
// ex_case_rr_arb
//   Two-way round-robin pick with the last-grant register.
//   Ports:
//     sclk, rst      clock, asynchronous active-high reset
//     req0, req1     request levels
//     grant_en       parent is able to accept a grant this cycle
//     pick_vld       at least one request present
//     pick_id        winning requester id (valid when pick_vld)
//   last_gnt resets to requester 1 so that requester 0 wins the first tie.
module ex_case_rr_arb
  import ex_case_pkg::*;
(
  input  logic sclk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic pick_vld,
  output logic pick_id
);

  logic last_gnt_reg;

  always_comb begin
    pick_vld = req0 | req1;
    // On a tie the requester that was not served last wins; otherwise the
    // lone requester wins (req1 alone -> id 1, req0 alone -> id 0).
    if (req0 && req1) begin
      pick_id = ~last_gnt_reg;
    end else begin
      pick_id = req1;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      last_gnt_reg <= REQ_ID1;
    end else if (grant_en && pick_vld) begin
      last_gnt_reg <= pick_id;
    end
  end

endmodule

// File: rtl/ex_case_burst_arb.sv
// ex_case_burst_arb
//   Round-robin arbiter and burst sequencer in front of the ex_case lookup
//   datapath. The granted requester's start address and length are latched;
//   an incrementing address/data burst is driven out, responses are counted
//   during the transaction and a one-cycle done pulse closes it.
//   Ports:
//     sclk, rst                          clock, asynchronous active-high reset
//     req0/1, start_addr0/1, len0/1      requester posts (level request)
//     gnt0/1                             requester owns the datapath
//     done0/1                            1-cycle completion pulse
//     cmd_vld, cmd_addr, cmd_data        beat stream to the datapath
//     rsp_dv, rsp_data                   datapath response (data unused)
//     rsp_cnt                            responses in current/last transaction
//     busy                               sequencer not idle
//   Timeline for a grant at edge g with length L (T = L+1+DRAIN_CYC, or
//   DRAIN_CYC for L=0): beats after edges g+1..g+L, done after edge g+T while
//   gnt is still high, gnt drops at edge g+T+1; no grant is taken during the
//   done cycle so there is always at least one idle cycle between bursts.
module ex_case_burst_arb
  import ex_case_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int RSP_W     = RSP_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
)(
  input  logic              sclk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] start_addr0,
  input  logic [LEN_W-1:0]  len0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] start_addr1,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt1,
  output logic              done1,
  output logic              cmd_vld,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              rsp_dv,
  input  logic [RSP_W-1:0]  rsp_data,
  output logic [LEN_W-1:0]  rsp_cnt,
  output logic              busy
);

  localparam int DRAIN_W = $clog2(DRAIN_CYC) + 1;

  state_t              state_reg, state_next;
  logic                gnt0_reg, gnt0_next;
  logic                gnt1_reg, gnt1_next;
  logic                done0_reg, done0_next;
  logic                done1_reg, done1_next;
  logic                cmd_vld_reg, cmd_vld_next;
  logic [ADDR_W-1:0]   cmd_addr_reg, cmd_addr_next;
  logic [DATA_W-1:0]   cmd_data_reg, cmd_data_next;
  logic [LEN_W-1:0]    rsp_cnt_reg, rsp_cnt_next;
  logic                busy_reg, busy_next;
  logic                id_reg, id_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [LEN_W-1:0]    len_reg, len_next;
  logic [LEN_W-1:0]    beat_reg, beat_next;
  logic [DRAIN_W-1:0]  drain_reg, drain_next;

  logic                grant_en;
  logic                pick_vld;
  logic                pick_id;
  logic [LEN_W-1:0]    sel_len;
  logic                unused_rsp;

  // Response payload is reserved for a future checksum.
  assign unused_rsp = ^rsp_data;

  // The done cycle is spent in IDLE with gnt still high; block a new grant
  // there so the finishing requester's still-high req is not re-granted.
  assign grant_en = (state_reg == ST_IDLE) && !done0_reg && !done1_reg;
  assign sel_len  = pick_id ? len1 : len0;

  ex_case_rr_arb u_rr_arb (
    .sclk     (sclk),
    .rst      (rst),
    .req0     (req0),
    .req1     (req1),
    .grant_en (grant_en),
    .pick_vld (pick_vld),
    .pick_id  (pick_id)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt0_next     = gnt0_reg;
    gnt1_next     = gnt1_reg;
    done0_next    = 1'b0;
    done1_next    = 1'b0;
    cmd_vld_next  = 1'b0;
    cmd_addr_next = '0;
    cmd_data_next = '0;
    busy_next     = busy_reg;
    id_next       = id_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    beat_next     = beat_reg;
    drain_next    = drain_reg;
    rsp_cnt_next  = rsp_cnt_reg;

    if (busy_reg && rsp_dv && (rsp_cnt_reg != '1)) begin
      rsp_cnt_next = rsp_cnt_reg + LEN_W'(1);
    end

    unique case (state_reg)
      ST_IDLE: begin
        if (done0_reg || done1_reg) begin
          gnt0_next = 1'b0;
          gnt1_next = 1'b0;
        end else if (pick_vld) begin
          gnt0_next    = (pick_id == REQ_ID0);
          gnt1_next    = (pick_id == REQ_ID1);
          busy_next    = 1'b1;
          id_next      = pick_id;
          addr_next    = pick_id ? start_addr1 : start_addr0;
          len_next     = sel_len;
          beat_next    = '0;
          drain_next   = '0;
          rsp_cnt_next = '0;
          state_next   = (sel_len != '0) ? ST_BURST : ST_DRAIN;
        end
      end
      ST_BURST: begin
        if (beat_reg != len_reg) begin
          cmd_vld_next  = 1'b1;
          cmd_addr_next = addr_reg;
          // {id, zero pad, address}
          cmd_data_next = DATA_W'(addr_reg);
          cmd_data_next[DATA_W-1] = id_reg;
          addr_next     = addr_reg + ADDR_W'(1);
          beat_next     = beat_reg + LEN_W'(1);
        end else begin
          drain_next = '0;
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == DRAIN_W'(DRAIN_CYC - 1)) begin
          done0_next = gnt0_reg;
          done1_next = gnt1_reg;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else begin
          drain_next = drain_reg + DRAIN_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b0;
      done0_reg    <= 1'b0;
      done1_reg    <= 1'b0;
      cmd_vld_reg  <= 1'b0;
      cmd_addr_reg <= '0;
      cmd_data_reg <= '0;
      rsp_cnt_reg  <= '0;
      busy_reg     <= 1'b0;
      id_reg       <= REQ_ID0;
      addr_reg     <= '0;
      len_reg      <= '0;
      beat_reg     <= '0;
      drain_reg    <= '0;
    end else begin
      gnt0_reg     <= gnt0_next;
      gnt1_reg     <= gnt1_next;
      done0_reg    <= done0_next;
      done1_reg    <= done1_next;
      cmd_vld_reg  <= cmd_vld_next;
      cmd_addr_reg <= cmd_addr_next;
      cmd_data_reg <= cmd_data_next;
      rsp_cnt_reg  <= rsp_cnt_next;
      busy_reg     <= busy_next;
      id_reg       <= id_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      beat_reg     <= beat_next;
      drain_reg    <= drain_next;
    end
  end

  assign gnt0     = gnt0_reg;
  assign gnt1     = gnt1_reg;
  assign done0    = done0_reg;
  assign done1    = done1_reg;
  assign cmd_vld  = cmd_vld_reg;
  assign cmd_addr = cmd_addr_reg;
  assign cmd_data = cmd_data_reg;
  assign rsp_cnt  = rsp_cnt_reg;
  assign busy     = busy_reg;

endmodule
